// File: rtl/bus_arbiter.sv
// Shares one external memory bus between fetch and data access (data first) and holds results until the pipeline advances.
// Optional watchdog: define BUS_ARB_TIMEOUT_EN to complete hung accesses after TIMEOUT_CYCLES with bus_err.
module bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  output logic                stallreq_from_bus,
  output logic                bus_err
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, MEM_ACC, IF_ACC, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [BE_W-1:0]     bus_be_q, bus_be_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic                if_pend, mem_pend;
  logic                load_if, load_mem;
  logic                acc_done;
  logic [DATA_W-1:0]   acc_rdata;

  assign if_pend           = if_req & ~if_done_q;
  assign mem_pend          = mem_req & ~mem_done_q;
  assign stallreq_from_bus = rst & (if_pend | mem_pend | (state_q == DRAIN));

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  logic             bus_err_q;

  assign timeout_hit = (state_q != IDLE) & ~bus_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign acc_done    = bus_ack | timeout_hit;
  assign acc_rdata   = bus_ack ? bus_rdata : '0;
  assign bus_err     = bus_err_q;

  // Counter restarts whenever a new ACC/DRAIN state is entered, including chained accesses.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)           cnt_d = '0;
    else if (state_q != IDLE && !bus_ack) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= timeout_hit;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign acc_done       = bus_ack;
  assign acc_rdata      = bus_rdata;
  assign bus_err        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    load_if     = 1'b0;
    load_mem    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (mem_pend)     load_mem = 1'b1;
          else if (if_pend) load_if  = 1'b1;
        end
      end
      MEM_ACC: begin
        if (acc_done) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
          if (!flush) begin
            mem_rdata_d = acc_rdata;
            mem_done_d  = 1'b1;
            load_if     = if_pend;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      IF_ACC: begin
        if (acc_done) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
          if (!flush) begin
            if_rdata_d = acc_rdata;
            if_done_d  = 1'b1;
            load_mem   = mem_pend;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Flushed transaction must still complete on the bus; its data is dropped.
        if (acc_done) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_mem) begin
      state_d     = MEM_ACC;
      bus_req_d   = 1'b1;
      bus_we_d    = mem_we;
      bus_be_d    = mem_be;
      bus_addr_d  = mem_addr;
      bus_wdata_d = mem_wdata;
    end else if (load_if) begin
      state_d    = IF_ACC;
      bus_req_d  = 1'b1;
      bus_we_d   = 1'b0;
      bus_be_d   = '1;
      bus_addr_d = if_addr;
    end

    // A cycle without stall is the pipeline advance; results have been consumed.
    if (flush || !stallreq_from_bus) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_be    = bus_be_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter: cycle table plus hand sequences for reset and timeout.
module tb_bus_arbiter;
  logic        clk, rst, flush;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, stallreq_from_bus, bus_err;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stallreq_from_bus(stallreq_from_bus), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl, ir;
    logic [31:0] ia;
    logic        mr, ack;
    logic [31:0] rd;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    logic        e_stall;
    logic [31:0] e_ifr, e_memr;
  } vec_t;

  localparam int NV = 36;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic fl, input logic ir, input logic [31:0] ia,
                              input logic mr, input logic ack, input logic [31:0] rd,
                              input logic e_req, input logic e_we, input logic [3:0] e_be,
                              input logic [31:0] e_addr, input logic [31:0] e_wd,
                              input logic e_stall, input logic [31:0] e_ifr,
                              input logic [31:0] e_memr);
    vec_t v;
    v.fl = fl; v.ir = ir; v.ia = ia; v.mr = mr; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_we = e_we; v.e_be = e_be; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_stall = e_stall; v.e_ifr = e_ifr; v.e_memr = e_memr;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] MR = 32'h1111_2222;

  initial begin
    // cycle table: inputs | bus_req we be addr wdata stall if_rdata mem_rdata
    tbl[0]  = mk(0,0,32'h0,        0,0,32'h0,        0,0,4'h0,32'h0,        32'h0,0,32'h0,        32'h0);
    tbl[1]  = mk(0,1,32'h8000_0000,0,0,32'h0,        0,0,4'h0,32'h0,        32'h0,1,32'h0,        32'h0);
    tbl[2]  = mk(0,1,32'h8000_0000,0,0,32'h0,        1,0,4'hF,32'h8000_0000,32'h0,1,32'h0,        32'h0);
    tbl[3]  = mk(0,1,32'h8000_0000,0,0,32'h0,        1,0,4'hF,32'h8000_0000,32'h0,1,32'h0,        32'h0);
    tbl[4]  = mk(0,1,32'h8000_0000,0,1,32'h2402_0001,1,0,4'hF,32'h8000_0000,32'h0,1,32'h0,        32'h0);
    tbl[5]  = mk(0,1,32'h8000_0000,0,0,32'h0,        0,0,4'hF,32'h8000_0000,32'h0,0,32'h2402_0001,32'h0);
    tbl[6]  = mk(0,0,32'h0,        0,0,32'h0,        0,0,4'hF,32'h8000_0000,32'h0,0,32'h2402_0001,32'h0);
    tbl[7]  = mk(0,1,32'h8000_0004,1,0,32'h0,        0,0,4'hF,32'h8000_0000,32'h0,1,32'h2402_0001,32'h0);
    tbl[8]  = mk(0,1,32'h8000_0004,1,0,32'h0,        1,1,4'h3,32'h8040_0010,DB,   1,32'h2402_0001,32'h0);
    tbl[9]  = mk(0,1,32'h8000_0004,1,1,MR,           1,1,4'h3,32'h8040_0010,DB,   1,32'h2402_0001,32'h0);
    tbl[10] = mk(0,1,32'h8000_0004,1,0,32'h0,        1,0,4'hF,32'h8000_0004,DB,   1,32'h2402_0001,MR);
    tbl[11] = mk(0,1,32'h8000_0004,1,1,32'h2403_0002,1,0,4'hF,32'h8000_0004,DB,   1,32'h2402_0001,MR);
    tbl[12] = mk(0,1,32'h8000_0004,1,0,32'h0,        0,0,4'hF,32'h8000_0004,DB,   0,32'h2403_0002,MR);
    tbl[13] = mk(0,0,32'h0,        0,0,32'h0,        0,0,4'hF,32'h8000_0004,DB,   0,32'h2403_0002,MR);
    tbl[14] = mk(0,1,32'h8000_0008,0,0,32'h0,        0,0,4'hF,32'h8000_0004,DB,   1,32'h2403_0002,MR);
    tbl[15] = mk(0,1,32'h8000_0008,0,0,32'h0,        1,0,4'hF,32'h8000_0008,DB,   1,32'h2403_0002,MR);
    tbl[16] = mk(1,1,32'h8000_0008,0,0,32'h0,        1,0,4'hF,32'h8000_0008,DB,   1,32'h2403_0002,MR);
    tbl[17] = mk(0,1,32'h8000_0100,0,0,32'h0,        1,0,4'hF,32'h8000_0008,DB,   1,32'h2403_0002,MR);
    tbl[18] = mk(0,1,32'h8000_0100,0,0,32'h0,        1,0,4'hF,32'h8000_0008,DB,   1,32'h2403_0002,MR);
    tbl[19] = mk(0,1,32'h8000_0100,0,1,32'hBAD0_BAD0,1,0,4'hF,32'h8000_0008,DB,   1,32'h2403_0002,MR);
    tbl[20] = mk(0,1,32'h8000_0100,0,0,32'h0,        0,0,4'hF,32'h8000_0008,DB,   1,32'h2403_0002,MR);
    tbl[21] = mk(0,1,32'h8000_0100,0,1,32'h0000_00AA,1,0,4'hF,32'h8000_0100,DB,   1,32'h2403_0002,MR);
    tbl[22] = mk(0,1,32'h8000_0100,0,0,32'h0,        0,0,4'hF,32'h8000_0100,DB,   0,32'h0000_00AA,MR);
    tbl[23] = mk(1,1,32'h8000_0104,0,0,32'h0,        0,0,4'hF,32'h8000_0100,DB,   1,32'h0000_00AA,MR);
    tbl[24] = mk(0,0,32'h0,        0,0,32'h0,        0,0,4'hF,32'h8000_0100,DB,   0,32'h0000_00AA,MR);
    tbl[25] = mk(0,1,32'h8000_0200,0,0,32'h0,        0,0,4'hF,32'h8000_0100,DB,   1,32'h0000_00AA,MR);
    tbl[26] = mk(0,1,32'h8000_0200,0,1,32'h1000_0001,1,0,4'hF,32'h8000_0200,DB,   1,32'h0000_00AA,MR);
    tbl[27] = mk(0,1,32'h8000_0200,0,0,32'h0,        0,0,4'hF,32'h8000_0200,DB,   0,32'h1000_0001,MR);
    tbl[28] = mk(0,1,32'h8000_0204,0,0,32'h0,        0,0,4'hF,32'h8000_0200,DB,   1,32'h1000_0001,MR);
    tbl[29] = mk(0,1,32'h8000_0204,0,1,32'h1000_0002,1,0,4'hF,32'h8000_0204,DB,   1,32'h1000_0001,MR);
    tbl[30] = mk(0,1,32'h8000_0204,0,0,32'h0,        0,0,4'hF,32'h8000_0204,DB,   0,32'h1000_0002,MR);
    tbl[31] = mk(0,1,32'h8000_0208,0,0,32'h0,        0,0,4'hF,32'h8000_0204,DB,   1,32'h1000_0002,MR);
    tbl[32] = mk(0,1,32'h8000_0208,0,1,32'h1000_0003,1,0,4'hF,32'h8000_0208,DB,   1,32'h1000_0002,MR);
    tbl[33] = mk(0,1,32'h8000_0208,0,0,32'h0,        0,0,4'hF,32'h8000_0208,DB,   0,32'h1000_0003,MR);
    tbl[34] = mk(0,0,32'h0,        0,1,32'hFFFF_FFFF,0,0,4'hF,32'h8000_0208,DB,   0,32'h1000_0003,MR);
    tbl[35] = mk(0,0,32'h0,        0,0,32'h0,        0,0,4'hF,32'h8000_0208,DB,   0,32'h1000_0003,MR);

    rst = 1'b0; flush = 1'b0; if_req = 1'b1; if_addr = 32'h8000_0000;
    mem_req = 1'b0; mem_we = 1'b1; mem_be = 4'b0011;
    mem_addr = 32'h8040_0010; mem_wdata = DB;
    bus_ack = 1'b0; bus_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_bus_req", -1, 32'(bus_req), 32'h0);
    chk("reset_stall_forced", -1, 32'(stallreq_from_bus), 32'h0);
    chk("reset_bus_addr", -1, bus_addr, 32'h0);
    chk("reset_bus_err", -1, 32'(bus_err), 32'h0);
    @(negedge clk);
    if_req = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      flush = tbl[i].fl; if_req = tbl[i].ir; if_addr = tbl[i].ia;
      mem_req = tbl[i].mr; bus_ack = tbl[i].ack; bus_rdata = tbl[i].rd;
      #1;
      chk("bus_req",   i, 32'(bus_req),           32'(tbl[i].e_req));
      chk("bus_we",    i, 32'(bus_we),            32'(tbl[i].e_we));
      chk("bus_be",    i, 32'(bus_be),            32'(tbl[i].e_be));
      chk("bus_addr",  i, bus_addr,               tbl[i].e_addr);
      chk("bus_wdata", i, bus_wdata,              tbl[i].e_wd);
      chk("stallreq",  i, 32'(stallreq_from_bus), 32'(tbl[i].e_stall));
      chk("if_rdata",  i, if_rdata,               tbl[i].e_ifr);
      chk("mem_rdata", i, mem_rdata,              tbl[i].e_memr);
      chk("bus_err",   i, 32'(bus_err),           32'h0);
    end

    // Reset asserted in the middle of a data read, request held across it.
    @(negedge clk);
    flush = 1'b0; if_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h8040_0020;
    #1;
    chk("rst_seq_stall_pre", 100, 32'(stallreq_from_bus), 32'h1);
    @(negedge clk);
    #1;
    chk("rst_seq_bus_req_act", 101, 32'(bus_req), 32'h1);
    chk("rst_seq_bus_addr_act", 101, bus_addr, 32'h8040_0020);
    #2 rst = 1'b0;
    #1;
    chk("rst_seq_bus_req_async", 102, 32'(bus_req), 32'h0);
    chk("rst_seq_bus_addr_async", 102, bus_addr, 32'h0);
    chk("rst_seq_bus_be_async", 102, 32'(bus_be), 32'h0);
    chk("rst_seq_if_rdata", 102, if_rdata, 32'h0);
    chk("rst_seq_mem_rdata", 102, mem_rdata, 32'h0);
    chk("rst_seq_stall_forced", 102, 32'(stallreq_from_bus), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_seq_idle_bus_req", 103, 32'(bus_req), 32'h0);
    chk("rst_seq_idle_stall", 103, 32'(stallreq_from_bus), 32'h1);
    @(negedge clk);
    #1;
    chk("rst_seq_restart_req", 104, 32'(bus_req), 32'h1);
    chk("rst_seq_restart_addr", 104, bus_addr, 32'h8040_0020);
    chk("rst_seq_restart_we", 104, 32'(bus_we), 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = '0;
    #1;
    chk("rst_seq_mem_rdata", 105, mem_rdata, 32'h5555_AAAA);
    chk("rst_seq_bus_req_drop", 105, 32'(bus_req), 32'h0);
    chk("rst_seq_stall_drop", 105, 32'(stallreq_from_bus), 32'h0);
    @(negedge clk);
    mem_req = 1'b0;

`ifdef BUS_ARB_TIMEOUT_EN
    // Read that never gets an ack: watchdog completes it after four cycles.
    @(negedge clk);
    mem_req = 1'b1; mem_addr = 32'h8040_0030;
    #1;
    chk("to_err_idle", 200, 32'(bus_err), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk("to_bus_req_wait", 200 + k, 32'(bus_req), 32'h1);
      chk("to_err_wait", 200 + k, 32'(bus_err), 32'h0);
    end
    @(negedge clk);
    #1;
    chk("to_err_pulse", 205, 32'(bus_err), 32'h1);
    chk("to_mem_rdata", 205, mem_rdata, 32'h0);
    chk("to_stall", 205, 32'(stallreq_from_bus), 32'h0);
    chk("to_bus_req", 205, 32'(bus_req), 32'h0);
    mem_req = 1'b0;
    @(negedge clk);
    #1;
    chk("to_err_end", 206, 32'(bus_err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single external memory bus between instruction fetch (IF) and data access (MEM); MEM has priority.
- Holds each result until the pipeline advances.
- Drives stallreq_from_bus into the pipeline controller, which holds all six stages.
- Takes flush from the controller so exception redirects discard in-flight results.

Parameters:
- ADDR_W, 32, bus/request address width
- DATA_W, 32, data width (byte enables DATA_W/8)
- TIMEOUT_CYCLES, 255, watchdog limit (used only with optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- flush  in  1  pipeline flush from controller
- if_req  in  1  fetch request, held until pipeline advances
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid while if_done
- mem_req  in  1  data request, held until pipeline advances
- mem_we  in  1  write enable
- mem_be  in  DATA_W/8  byte enables
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data
- mem_rdata  out  DATA_W  read data, valid while mem_done
- bus_req  out  1  bus request, registered
- bus_we  out  1  registered
- bus_be  out  DATA_W/8  registered (all ones for IF)
- bus_addr  out  ADDR_W  registered
- bus_wdata  out  DATA_W  registered
- bus_rdata  in  DATA_W  valid in bus_ack cycle
- bus_ack  in  1  single-cycle completion pulse
- stallreq_from_bus  out  1  combinational stall request
- bus_err  out  1  one-cycle pulse on timeout (optional feature only, else tied 0)

Behaviour:
- Reset (rst=0, async): state IDLE; all bus_* outputs 0; if_rdata/mem_rdata 0; internal if_done/mem_done 0; bus_err 0.
- States: IDLE, MEM_ACC, IF_ACC, DRAIN.
- stallreq_from_bus = (if_req & ~if_done) | (mem_req & ~mem_done) | (state==DRAIN). Forced 0 during reset.
- IDLE:
  - mem_req & ~mem_done & ~flush: load bus regs from mem_*, go MEM_ACC. bus_req rises next cycle.
  - Otherwise if_req & ~if_done & ~flush: load if_addr, bus_we=0, bus_be=all ones, go IF_ACC.
- MEM_ACC/IF_ACC:
  - Bus outputs held stable until bus_ack.
  - On bus_ack: latch bus_rdata into mem_rdata/if_rdata (writes latch it too, value unused) and set the matching done flag.
  - If the other request is pending and not done, reload bus regs in the same edge and chain directly to the other ACC state (bus_req stays 1). Else drop bus_req and go IDLE.
- Done clearing: at an edge where stallreq_from_bus=0, both done flags clear; that cycle is the pipeline advance. Outputs keep last value.
- flush while in ACC with no bus_ack that cycle:
  - Go DRAIN. Bus transaction continues (no abort).
  - On bus_ack: drop bus_req, discard data, go IDLE.
- flush in the same cycle as bus_ack: discard data, go IDLE.
- flush in any state clears both done flags. No new access starts in a flush cycle.
- Simultaneous if_req and mem_req: MEM first, then IF chained. The access sequence is a fixed MEM→IF order.
- bus_ack outside an ACC/DRAIN state is ignored.
- Minimum latency: request seen at edge t → bus_req at t+1. bus_ack at cycle t+1+k makes done valid after edge t+2+k.

Optional Feature:
- Macro BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter resets on entering any ACC/DRAIN state and increments each cycle without bus_ack.
  - When it reaches TIMEOUT_CYCLES: treat the access as completed with rdata 0, pulse bus_err for 1 cycle, drop bus_req, follow the normal post-ack transition.
- Undefined: no counter; bus_err tied 0; access waits indefinitely.

Test Plan:
- IF only: if_req=1, if_addr=0x8000_0000, bus_ack 2 cycles after bus_req with rdata 0x2402_0001 → bus_addr=0x8000_0000, bus_be=4'hF, if_rdata=0x2402_0001; stallreq high 4 cycles then low; if_done clears next edge.
- Simultaneous: mem_req write addr 0x8040_0010, wdata 0xDEAD_BEEF, be 4'b0011, plus if_req → write issued first; on ack chains directly to IF with no bus_req gap; stallreq drops only after IF ack.
- Flush mid-IF: flush 1 cycle after bus_req, bus_ack 3 cycles later → state DRAIN, stallreq held until ack, if_rdata unchanged, no new access started in the flush cycle.
- Reset mid-access: rst=0 during MEM_ACC → bus_req=0 immediately (async), outputs 0; after release with requests held, MEM access restarts from IDLE.
- Timeout (BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): bus_ack never arrives → bus_err pulses once at cycle 4, mem_rdata=0, stallreq drops.
- Back-to-back instructions: 3 consecutive IF-only fetches with immediate ack → done flags clear each advance; each if_rdata matches its own bus_rdata.
